// File: rtl/router_pkt_tx_if.sv
// Byte-stream bundle between the packet transmitter and its requester/router.
// The master side requests packets and applies busy; the slave side is the transmitter.
interface router_pkt_tx_if;
    logic       start;
    logic [5:0] len;
    logic [1:0] addr;
    logic       mode;
    logic [7:0] seed;
    logic       corrupt;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       ready;
    logic       done;
    logic       reject;

    modport master (
        output start, len, addr, mode, seed, corrupt, busy,
        input  pkt_valid, data_out, ready, done, reject
    );

    modport slave (
        input  start, len, addr, mode, seed, corrupt, busy,
        output pkt_valid, data_out, ready, done, reject
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: header {len,addr}, len generated payload bytes, then a parity
// byte with pkt_valid low. Every output comes straight from a register.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 1
) (
    input  logic              clock,
    input  logic              resetn,
    router_pkt_tx_if.slave    tx
);
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;
    logic       reject_q, reject_d;
    logic [5:0] len_q, len_d;
    logic       mode_q, mode_d;
    logic       corrupt_q, corrupt_d;
    logic [7:0] gen_q, gen_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] par_q, par_d;
    logic [3:0] gap_q, gap_d;
    logic [5:0] cnt_inc;
    logic [7:0] par_new;

    // gen_q always holds the byte that will be presented after the current one.
    function automatic logic [7:0] gen_next(input logic m, input logic [7:0] v);
        if (m)
            return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        else
            return v + 8'd1;
    endfunction

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        reject_d  = 1'b0;
        len_d     = len_q;
        mode_d    = mode_q;
        corrupt_d = corrupt_q;
        gen_d     = gen_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        gap_d     = gap_q;
        cnt_inc   = cnt_q + 6'd1;
        par_new   = par_q ^ data_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (tx.start) begin
                    if (tx.len == 6'd0 || tx.addr == 2'd3) begin
                        reject_d = 1'b1;
                    end else begin
                        len_d     = tx.len;
                        mode_d    = tx.mode;
                        corrupt_d = tx.corrupt;
                        gen_d     = (tx.mode && tx.seed == 8'd0) ? 8'd1 : tx.seed;
                        cnt_d     = 6'd0;
                        data_d    = {tx.len, tx.addr};
                        valid_d   = 1'b1;
                        state_d   = HEADER;
                    end
                end
            end
            HEADER: begin
                if (!tx.busy) begin
                    par_d   = data_q;
                    data_d  = gen_q;
                    gen_d   = gen_next(mode_q, gen_q);
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!tx.busy) begin
                    par_d = par_new;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        valid_d = 1'b0;
                        data_d  = corrupt_q ? ~par_new : par_new;
                        state_d = PARITY;
                    end else begin
                        data_d = gen_q;
                        gen_d  = gen_next(mode_q, gen_q);
                    end
                end
            end
            PARITY: begin
                if (!tx.busy) begin
                    done_d = 1'b1;
                    data_d = 8'h00;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = 4'd0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                // The done cycle is the first gap cycle.
                if (gap_q == GAP_LAST)
                    state_d = IDLE;
                else
                    gap_d = gap_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q   <= IDLE;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
            len_q     <= 6'd0;
            mode_q    <= 1'b0;
            corrupt_q <= 1'b0;
            gen_q     <= 8'h00;
            cnt_q     <= 6'd0;
            par_q     <= 8'h00;
            gap_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            corrupt_q <= corrupt_d;
            gen_q     <= gen_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            gap_q     <= gap_d;
        end
    end

    assign tx.pkt_valid = valid_q;
    assign tx.data_out  = data_q;
    assign tx.ready     = ready_q;
    assign tx.done      = done_q;
    assign tx.reject    = reject_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed test-plan packets plus random packets with random
// busy stalls, each checked cycle by cycle against a byte-list model of the packet.
module tb_router_pkt_tx;
    localparam int GAP = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    router_pkt_tx_if tx_if ();

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clock  (clock),
        .resetn (resetn),
        .tx     (tx_if.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_lfsr(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    // Starts and ends at a negedge where ready is expected high.
    task automatic run_packet(input int len, input int addr, input bit mode, input logic [7:0] seed,
                              input bit corrupt, input bit hold, input int busy_pct,
                              input int stall_idx, input int stall_n, input int abort_at);
        logic [7:0] exp_b[$];
        logic [7:0] v;
        logic [7:0] par;
        int i;
        int stalls;
        int run;
        bit last_busy;
        exp_b.push_back({len[5:0], addr[1:0]});
        v = seed;
        if (mode && v == 8'h00) v = 8'h01;
        for (int k = 0; k < len; k++) begin
            exp_b.push_back(v);
            v = mode ? model_lfsr(v) : v + 8'd1;
        end
        par = 8'h00;
        foreach (exp_b[k]) par ^= exp_b[k];
        if (corrupt) par = ~par;

        check("start_ready", 32'(tx_if.ready), 1);
        tx_if.start   = 1'b1;
        tx_if.len     = len[5:0];
        tx_if.addr    = addr[1:0];
        tx_if.mode    = mode;
        tx_if.seed    = seed;
        tx_if.corrupt = corrupt;
        tx_if.busy    = 1'b0;
        @(negedge clock);
        if (!hold) tx_if.start = 1'b0;

        i = 0; stalls = 0; run = 0;
        while (i < exp_b.size()) begin
            check("byte_valid", 32'(tx_if.pkt_valid), 1);
            check("byte_data", 32'(tx_if.data_out), 32'(exp_b[i]));
            check("byte_ready", 32'(tx_if.ready), 0);
            check("byte_done", 32'(tx_if.done), 0);
            if (i == abort_at) begin
                resetn = 1'b1; tx_if.start = 1'b0; tx_if.busy = 1'b0;
                @(negedge clock);
                resetn = 1'b0;
                check("abort_valid", 32'(tx_if.pkt_valid), 0);
                check("abort_data", 32'(tx_if.data_out), 0);
                check("abort_ready", 32'(tx_if.ready), 1);
                check("abort_done", 32'(tx_if.done), 0);
                check("abort_reject", 32'(tx_if.reject), 0);
                @(negedge clock);
                check("abort_nodone", 32'(tx_if.done), 0);
                check("abort_idle", 32'(tx_if.ready), 1);
                return;
            end
            if (!hold) begin
                // Request inputs are scrambled mid-packet; the latched values must win.
                tx_if.start   = 1'($urandom_range(0, 1));
                tx_if.len     = 6'($urandom);
                tx_if.addr    = 2'($urandom);
                tx_if.mode    = 1'($urandom_range(0, 1));
                tx_if.seed    = 8'($urandom);
                tx_if.corrupt = 1'($urandom_range(0, 1));
            end
            if (i == stall_idx && stalls < stall_n) begin
                tx_if.busy = 1'b1; stalls++;
            end else if (run < 3 && $urandom_range(0, 99) < busy_pct) begin
                tx_if.busy = 1'b1; run++;
            end else begin
                tx_if.busy = 1'b0; run = 0;
            end
            last_busy = tx_if.busy;
            @(negedge clock);
            if (!last_busy) i++;
        end

        run = 0;
        do begin
            check("par_valid", 32'(tx_if.pkt_valid), 0);
            check("par_data", 32'(tx_if.data_out), 32'(par));
            check("par_done", 32'(tx_if.done), 0);
            if (run < 3 && $urandom_range(0, 99) < busy_pct) begin
                tx_if.busy = 1'b1; run++;
            end else begin
                tx_if.busy = 1'b0;
            end
            last_busy = tx_if.busy;
            @(negedge clock);
        end while (last_busy);

        if (!hold) tx_if.start = 1'b0;
        check("done_pulse", 32'(tx_if.done), 1);
        check("done_valid", 32'(tx_if.pkt_valid), 0);
        check("done_ready", 32'(tx_if.ready), 32'(GAP == 0));
        for (int g = 1; g < GAP; g++) begin
            @(negedge clock);
            check("gap_ready", 32'(tx_if.ready), 0);
            check("gap_done", 32'(tx_if.done), 0);
            check("gap_valid", 32'(tx_if.pkt_valid), 0);
        end
        @(negedge clock);
        check("ready_back", 32'(tx_if.ready), 1);
        check("ready_done", 32'(tx_if.done), 0);
    endtask

    initial begin
        tx_if.start = 1'b0; tx_if.len = 6'd0; tx_if.addr = 2'd0; tx_if.mode = 1'b0;
        tx_if.seed = 8'h00; tx_if.corrupt = 1'b0; tx_if.busy = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_valid", 32'(tx_if.pkt_valid), 0);
        check("rst_data", 32'(tx_if.data_out), 0);
        check("rst_ready", 32'(tx_if.ready), 1);
        check("rst_done", 32'(tx_if.done), 0);
        check("rst_reject", 32'(tx_if.reject), 0);
        resetn = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 32'(tx_if.ready), 1);

        run_packet(5, 2, 1'b0, 8'h10, 1'b0, 1'b0, 0, -1, 0, -1);
        run_packet(5, 2, 1'b0, 8'h10, 1'b1, 1'b0, 0, -1, 0, -1);
        run_packet(5, 2, 1'b0, 8'h10, 1'b0, 1'b0, 0, 3, 3, -1);

        tx_if.start = 1'b1; tx_if.len = 6'd0; tx_if.addr = 2'd1;
        @(negedge clock);
        check("rej_len0", 32'(tx_if.reject), 1);
        check("rej_len0_valid", 32'(tx_if.pkt_valid), 0);
        check("rej_len0_ready", 32'(tx_if.ready), 1);
        @(negedge clock);
        check("rej_held", 32'(tx_if.reject), 1);
        tx_if.len = 6'd5; tx_if.addr = 2'd3;
        @(negedge clock);
        check("rej_addr3", 32'(tx_if.reject), 1);
        check("rej_addr3_valid", 32'(tx_if.pkt_valid), 0);
        check("rej_addr3_ready", 32'(tx_if.ready), 1);
        tx_if.start = 1'b0;
        @(negedge clock);
        check("rej_clear", 32'(tx_if.reject), 0);
        check("rej_clear_ready", 32'(tx_if.ready), 1);

        for (int p = 0; p < 3; p++)
            run_packet(1, 1, 1'b1, 8'h00, 1'b0, 1'b1, 0, -1, 0, -1);
        tx_if.start = 1'b0;
        @(negedge clock);
        check("hold_stop_ready", 32'(tx_if.ready), 1);
        check("hold_stop_valid", 32'(tx_if.pkt_valid), 0);

        run_packet(5, 2, 1'b0, 8'h10, 1'b0, 1'b0, 0, -1, 0, 3);
        run_packet(5, 2, 1'b0, 8'h10, 1'b0, 1'b0, 0, -1, 0, -1);

        for (int p = 0; p < 20; p++)
            run_packet(int'($urandom_range(1, 63)), int'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                       1'b0, 30, -1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
